// File: rtl/alu_seq.sv
// alu_seq: handshaked saturating ALU with iterative shifts and an N/V/Z flag register
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter int SHW        = 4,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, result_q, result_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [2:0]       op_q, op_d, flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        logic [4:0]       s;
        r = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            s = {x[4*i+3], x[4*i+:4]} + {y[4*i+3], y[4*i+:4]};
            r[4*i+:4] = (s[4] ^ s[3]) ? {s[4], {3{~s[4]}}} : s[3:0];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] red(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH/8; i++)
            acc = acc + WIDTH'($signed(x[8*i+:8])) + WIDTH'($signed(y[8*i+:8]));
        return acc;
    endfunction

    logic [WIDTH-1:0]   b_eff, arith_res, alu_res, shifted;
    logic [WIDTH:0]     sum;
    logic               ov, is_arith, is_shift;
    logic [SHW-1:0]     step;
    logic [2*WIDTH-1:0] rot;

    always_comb begin
        b_eff     = ctl[0] ? ~b : b;
        sum       = {a[WIDTH-1], a} + {b_eff[WIDTH-1], b_eff} + (WIDTH+1)'(ctl[0]);
        ov        = sum[WIDTH] ^ sum[WIDTH-1];
        arith_res = ov ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}} : sum[WIDTH-1:0];
        is_arith  = ctl[2:1] == 2'b00;
        is_shift  = ctl[2] & ~(ctl[1] & ctl[0]);
        alu_res   = is_arith        ? arith_res   :
                    ctl == 3'b010   ? paddsb(a, b) :
                    ctl == 3'b011   ? red(a, b)    :
                    ctl == 3'b111   ? a ^ b        : a;
        // Final step of a shift may be shorter than SHIFT_STEP
        step      = (rem_q < STEP) ? rem_q : STEP;
        rot       = {work_q, work_q} >> step;
        shifted   = op_q == 3'b100 ? work_q << step :
                    op_q == 3'b101 ? WIDTH'($signed(work_q) >>> step) : rot[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        op_d        = op_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d   = ctl;
                work_d = a;
                rem_d  = b[SHW-1:0];
                if (is_shift && b[SHW-1:0] != '0) begin
                    state_d = SHIFT;
                end else begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    flags_d     = is_arith ? {alu_res == '0, ov, alu_res[WIDTH-1]}
                                           : {alu_res == '0, flags_q[1:0]};
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step;
                if (rem_d == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = shifted;
                    flags_d     = {shifted == '0, flags_q[1:0]};
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, scoreboard queue checked by a monitor on each output handshake
module tb_alu_seq;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, busy;
    logic [15:0] a = 0, b = 0, result;
    logic [2:0]  ctl = 0, flags;
    int          tests = 0, fails = 0;
    logic [18:0] exp_q[$];
    string       name_q[$];
    logic [18:0] e;
    string       n;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctl(ctl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result %h expected no output", result);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_result"}, {16'h0, result}, {16'h0, e[18:3]});
                check({n, "_flags"}, {29'h0, flags}, {29'h0, e[2:0]});
            end
        end
    end

    task automatic wait_ready(input string nm);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check({nm, "_ready_timeout"}, {31'h0, in_ready}, 32'd1);
    endtask

    task automatic issue(input string nm, input logic [2:0] c, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic [2:0] ef, input int elat);
        int lat;
        wait_ready(nm);
        ctl = c; a = x; b = y; in_valid = 1;
        exp_q.push_back({er, ef});
        name_q.push_back(nm);
        @(posedge clk);
        #1 in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, lat, elat);
    endtask

    initial begin
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_flags", {29'h0, flags}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;

        issue("add_sat",    3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 1);
        issue("sub_zero",   3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b100, 1);
        issue("paddsb",     3'b010, 16'h7878, 16'h1111, 16'h7979, 3'b000, 1);
        issue("red",        3'b011, 16'hFF01, 16'h0203, 16'h0005, 3'b000, 1);
        issue("xor_zero",   3'b111, 16'hA5A5, 16'hA5A5, 16'h0000, 3'b100, 1);
        issue("sra4",       3'b101, 16'h8001, 16'h0004, 16'hF800, 3'b000, 5);
        issue("ror1",       3'b110, 16'h0001, 16'h0001, 16'h8000, 3'b000, 2);
        issue("ror8",       3'b110, 16'h0003, 16'h0008, 16'h0300, 3'b000, 9);
        issue("sll0",       3'b100, 16'h1234, 16'h0000, 16'h1234, 3'b000, 1);
        issue("add_negsat", 3'b000, 16'h8000, 16'hFFFF, 16'h8000, 3'b011, 1);
        issue("paddsb_neg", 3'b010, 16'h8888, 16'h8888, 16'h8888, 3'b011, 1);

        wait_ready("rst_mid");
        ctl = 3'b100; a = 16'h0001; b = 16'h000F; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        check("shift_busy", {31'h0, busy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("mid_rst_result", {16'h0, result}, 32'h0);
        check("mid_rst_flags", {29'h0, flags}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
        #2 rst = 0;
        issue("add_after_rst", 3'b000, 16'h0001, 16'h0002, 16'h0003, 3'b000, 1);

        wait_ready("bp");
        out_ready = 0;
        ctl = 3'b111; a = 16'h00FF; b = 16'h0F0F; in_valid = 1;
        exp_q.push_back({16'h0FF0, 3'b000});
        name_q.push_back("bp_xor");
        @(posedge clk);
        #1;
        check("bp_out_valid", {31'h0, out_valid}, 32'd1);
        ctl = 3'b001; a = 16'h0000; b = 16'h0001;
        exp_q.push_back({16'hFFFF, 3'b001});
        name_q.push_back("bp_sub");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
            check("bp_hold_valid", {31'h0, out_valid}, 32'd1);
            check("bp_hold_result", {16'h0, result}, 32'h0FF0);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {31'h0, in_ready}, 32'd1);
        check("bp_release_valid", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1 in_valid = 0;
        check("bp_pending_accepted", {31'h0, out_valid}, 32'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
